// File: rtl/softmax_outp_writeback_if.sv
// softmax_outp_writeback_if: result-vector stream in, memory write port out
interface softmax_outp_writeback_if #(
    parameter int DATAWIDTH = 16,
    parameter int NUM       = 4,
    parameter int ADDRSIZE  = 8
);
    logic                      outp_valid;
    logic [DATAWIDTH*NUM-1:0]  outp;
    logic                      mem_ready;
    logic                      wr_en;
    logic [ADDRSIZE-1:0]       wr_addr;
    logic [DATAWIDTH*NUM-1:0]  wr_data;
    modport master (output outp_valid, outp, mem_ready, input wr_en, wr_addr, wr_data);
    modport slave  (input outp_valid, outp, mem_ready, output wr_en, wr_addr, wr_data);
endinterface

// File: rtl/softmax_outp_writeback.sv
// softmax_outp_writeback: buffers softmax result vectors and writes them to start..end-1
module softmax_outp_writeback #(
    parameter int DATAWIDTH  = 16,
    parameter int NUM        = 4,
    parameter int ADDRSIZE   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDRSIZE-1:0]   start_addr,
    input  logic [ADDRSIZE-1:0]   end_addr,
    softmax_outp_writeback_if.slave bus,
    output logic                  busy,
    output logic                  wb_done,
    output logic                  overflow_err
);
    localparam int W  = DATAWIDTH * NUM;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDRSIZE-1:0] wr_ptr_q, wr_ptr_d, push_ptr_q, push_ptr_d, end_q, end_d;
    logic [ADDRSIZE-1:0] wr_addr_q, wr_addr_d, wr_ptr_inc;
    logic [PW-1:0]       rd_q, rd_d, wp_q, wp_d;
    logic [PW:0]         cnt_q, cnt_d;
    logic [W-1:0]        mem_q [FIFO_DEPTH];
    logic [W-1:0]        mem_d [FIFO_DEPTH];
    logic [W-1:0]        wr_data_q, wr_data_d;
    logic                wr_en_q, wr_en_d, wb_done_q, wb_done_d, ovf_q, ovf_d;
    logic                start, empty, full, pop, room, more, push, drop, last_pop;

    // Handshake decode: a pop frees a slot for a push at the same edge
    always_comb begin
        start      = (state_q == IDLE) && init;
        empty      = (cnt_q == '0);
        full       = (cnt_q == (PW+1)'(FIFO_DEPTH));
        pop        = (state_q == RUN) && !empty && bus.mem_ready;
        room       = !full || pop;
        more       = (push_ptr_q != end_q);
        push       = (state_q == RUN) && bus.outp_valid && more && room;
        drop       = (state_q == RUN) && bus.outp_valid && !(more && room);
        wr_ptr_inc = wr_ptr_q + 1'b1;
        last_pop   = pop && (wr_ptr_inc == end_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: an empty or inverted range skips straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (init) state_d = (start_addr >= end_addr) ? DONE : RUN;
            RUN:     if (last_pop) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q != IDLE);
        wb_done_d = (state_q == DONE);
    end

    // Datapath next values: FIFO, address pointers, registered write port
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        push_ptr_d = push_ptr_q;
        end_d      = end_q;
        rd_d       = rd_q;
        wp_d       = wp_q;
        mem_d      = mem_q;
        ovf_d      = ovf_q;
        if (start) begin
            wr_ptr_d   = start_addr;
            push_ptr_d = start_addr;
            end_d      = end_addr;
            rd_d       = '0;
            wp_d       = '0;
            ovf_d      = 1'b0;
        end
        if (push) begin
            mem_d[wp_q] = bus.outp;
            wp_d        = wp_q + 1'b1;
            push_ptr_d  = push_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_d     = rd_q + 1'b1;
            wr_ptr_d = wr_ptr_inc;
        end
        if (drop) ovf_d = 1'b1;
        cnt_d     = start ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        wr_en_d   = pop;
        wr_addr_d = pop ? wr_ptr_q : wr_addr_q;
        wr_data_d = pop ? mem_q[rd_q] : wr_data_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            push_ptr_q <= '0;
            end_q      <= '0;
            rd_q       <= '0;
            wp_q       <= '0;
            cnt_q      <= '0;
            mem_q      <= '{default: '0};
            ovf_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wb_done_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            push_ptr_q <= push_ptr_d;
            end_q      <= end_d;
            rd_q       <= rd_d;
            wp_q       <= wp_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
            ovf_q      <= ovf_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wb_done_q  <= wb_done_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign wb_done      = wb_done_q;
    assign overflow_err = ovf_q;
endmodule

// File: tb/tb_softmax_outp_writeback.sv
// tb_softmax_outp_writeback: directed + random stimulus against a queue-based reference model
module tb_softmax_outp_writeback;
    localparam int DW = 16, N = 4, AW = 8, D = 4, W = DW * N;
    localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;

    logic          clk = 1'b0, reset = 1'b0, init = 1'b0;
    logic [AW-1:0] start_addr = '0, end_addr = '0;
    logic          busy, wb_done, overflow_err;
    int            checks = 0, errors = 0;

    softmax_outp_writeback_if #(.DATAWIDTH(DW), .NUM(N), .ADDRSIZE(AW)) bus ();

    softmax_outp_writeback #(.DATAWIDTH(DW), .NUM(N), .ADDRSIZE(AW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .init(init), .start_addr(start_addr), .end_addr(end_addr),
        .bus(bus), .busy(busy), .wb_done(wb_done), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of buffered vectors plus the write cursor
    logic [W-1:0]  q[$];
    int            phase = P_IDLE, m_wptr, m_end, m_count, m_pushed;
    bit            m_ovf, m_we, m_wb;
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_data;

    task automatic model_edge();
        if (!reset) begin
            phase = P_IDLE; q.delete(); m_ovf = 0; m_we = 0; m_wb = 0; m_addr = '0; m_data = '0;
        end else begin
            m_wb = (phase == P_DONE);
            m_we = 0;
            if (phase == P_IDLE) begin
                if (init) begin
                    m_wptr = int'(start_addr); m_end = int'(end_addr);
                    m_count = m_end - m_wptr; m_pushed = 0; m_ovf = 0; q.delete();
                    phase = (start_addr >= end_addr) ? P_DONE : P_RUN;
                end
            end else if (phase == P_DONE) begin
                phase = P_IDLE;
            end else begin
                bit pop;
                logic [W-1:0] head;
                pop = (q.size() > 0) && bus.mem_ready;
                head = '0;
                if (pop) head = q.pop_front();
                if (bus.outp_valid) begin
                    if (m_pushed < m_count && q.size() < D) begin
                        q.push_back(bus.outp); m_pushed++;
                    end else m_ovf = 1;
                end
                if (pop) begin
                    m_we = 1; m_addr = AW'(m_wptr); m_data = head; m_wptr++;
                    if (m_wptr == m_end) phase = P_DONE;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("wr_en", 64'(bus.wr_en), 64'(m_we));
        chk("wr_addr", 64'(bus.wr_addr), 64'(m_addr));
        chk("wr_data", bus.wr_data, m_data);
        chk("busy", 64'(busy), 64'(phase != P_IDLE));
        chk("wb_done", 64'(wb_done), 64'(m_wb));
        chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    endtask

    task automatic drive(input bit i, input bit v, input bit r);
        init = i; bus.outp_valid = v; bus.mem_ready = r; bus.outp = {$urandom, $urandom};
    endtask

    task automatic arm(input logic [AW-1:0] s, input logic [AW-1:0] e, input bit r);
        start_addr = s; end_addr = e; drive(1, 0, r); cyc(); drive(0, 0, r);
    endtask

    initial begin
        drive(0, 0, 0);
        cyc(); cyc();
        reset = 1'b1;
        // Basic run
        arm(8'h10, 8'h14, 1);
        repeat (4) begin drive(0, 1, 1); cyc(); end
        drive(0, 0, 1); repeat (6) cyc();
        chk("basic_ovf", 64'(overflow_err), 64'd0);
        // Stall while vectors arrive
        arm(8'h10, 8'h14, 0);
        repeat (4) begin drive(0, 1, 0); cyc(); end
        drive(0, 0, 0); cyc(); cyc();
        drive(0, 0, 1); repeat (8) cyc();
        // Overflow: fifth vector with the FIFO full and memory stalled
        arm(8'h30, 8'h38, 0);
        repeat (5) begin drive(0, 1, 0); cyc(); end
        chk("ovf_set", 64'(overflow_err), 64'd1);
        drive(0, 0, 1); repeat (6) cyc();
        repeat (4) begin drive(0, 1, 1); cyc(); end
        drive(0, 0, 1); repeat (8) cyc();
        // Empty range
        arm(8'h20, 8'h20, 1);
        chk("empty_early", 64'(wb_done), 64'd0);
        cyc();
        chk("empty_done", 64'(wb_done), 64'd1);
        repeat (3) cyc();
        // Full FIFO with simultaneous push and pop
        arm(8'h40, 8'h48, 0);
        repeat (4) begin drive(0, 1, 0); cyc(); end
        drive(0, 1, 1); cyc();
        chk("simul_ovf", 64'(overflow_err), 64'd0);
        repeat (3) begin drive(0, 1, 1); cyc(); end
        drive(0, 0, 1); repeat (8) cyc();
        // Reset after two writes, then a clean restart
        arm(8'h50, 8'h54, 1);
        repeat (3) begin drive(0, 1, 1); cyc(); end
        reset = 1'b0; cyc();
        chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1; drive(0, 0, 1); repeat (3) cyc();
        arm(8'h50, 8'h54, 1);
        repeat (4) begin drive(0, 1, 1); cyc(); end
        drive(0, 0, 1); repeat (6) cyc();
        // Random ranges, traffic, stray inits and occasional resets
        for (int t = 0; t < 14; t++) begin
            logic [AW-1:0] s, e;
            s = AW'($urandom_range(0, 240));
            e = (t % 5 == 4) ? s - AW'($urandom_range(0, 3)) : s + AW'($urandom_range(1, 10));
            arm(s, e, 1);
            for (int c = 0; c < 60; c++) begin
                drive(($urandom % 10) == 0, $urandom % 2, ($urandom % 3) != 0);
                cyc();
            end
            drive(0, 0, 1); repeat (3) cyc();
            if (t % 4 == 3) begin reset = 1'b0; cyc(); reset = 1'b1; end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
